v1_peak_ctrl: RTL and testbench

//  Event sequencer placed after v1_filter (trapezoidal shaper).
//  - Arms on a threshold crossing of the shaped output.
//  - Waits a programmable flat-top delay, then captures amplitude plus timestamp.
//  - Rejects short pulses, enforces a hold-off, and hands events downstream via a 1-entry valid/ready buffer.

---
 rtl/v1_peak_ctrl.sv | 141 ++++++++++++++
 tb/tb_v1_peak_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/v1_peak_ctrl.sv
// Peak sequencer after the trapezoidal shaper: arms on a threshold crossing, captures amplitude and timestamp
// after a flat-top delay, and buffers one event downstream. Define V1_PEAK_MAX_EN to capture the maximum over the window.
module v1_peak_ctrl #(
  parameter int DW         = 16,
  parameter int TS_WIDTH   = 32,
  parameter int CNT_WIDTH  = 8,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DW-1:0]         filter_data,
  input  logic [DW-1:0]         threshold,
  input  logic [CNT_WIDTH-1:0]  peak_delay,
  input  logic [CNT_WIDTH-1:0]  holdoff,
  output logic                  event_valid,
  input  logic                  event_ready,
  output logic [DW-1:0]         event_amp,
  output logic [TS_WIDTH-1:0]   event_ts,
  output logic                  busy,
  output logic [STAT_WIDTH-1:0] drop_cnt,
  output logic [STAT_WIDTH-1:0] reject_cnt,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RISE    = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [TS_WIDTH-1:0]   ts_cnt;
  logic [TS_WIDTH-1:0]   ts_latch;
  logic                  above_d;

  logic                  above;
  logic                  crossing;
  logic [CNT_WIDTH-1:0]  d_load;
  logic [CNT_WIDTH-1:0]  h_load;
  logic                  capture;
  logic [DW-1:0]         peak_sample;

  assign above    = $signed(filter_data) > $signed(threshold);
  assign crossing = above && !above_d;
  // A programmed value of zero still means one cycle in RISE / HOLDOFF.
  assign d_load   = (peak_delay == '0) ? CNT_ONE : peak_delay;
  assign h_load   = (holdoff == '0) ? CNT_ONE : holdoff;
  assign capture  = enable && (state == RISE) && above && (cnt == CNT_ONE);

`ifdef V1_PEAK_MAX_EN
  logic [DW-1:0] run_max;
  assign peak_sample = ($signed(filter_data) > $signed(run_max)) ? filter_data : run_max;
`else
  assign peak_sample = filter_data;
`endif

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Sequencer FSM, timestamp counter and reject statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ts_cnt     <= '0;
      ts_latch   <= '0;
      above_d    <= 1'b0;
      reject_cnt <= '0;
`ifdef V1_PEAK_MAX_EN
      run_max    <= '0;
`endif
    end else begin
      ts_cnt  <= ts_cnt + 1'b1;
      above_d <= above;
      if (!enable) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (crossing) begin
              state    <= RISE;
              cnt      <= d_load;
              ts_latch <= ts_cnt;
`ifdef V1_PEAK_MAX_EN
              run_max  <= {1'b1, {(DW-1){1'b0}}};
`endif
            end
          end
          RISE: begin
            if (!above) begin
              state <= IDLE;
              if (reject_cnt != '1) reject_cnt <= reject_cnt + 1'b1;
            end else begin
`ifdef V1_PEAK_MAX_EN
              run_max <= peak_sample;
`endif
              if (cnt == CNT_ONE) begin
                state <= HOLDOFF;
                cnt   <= h_load;
              end else begin
                cnt <= cnt - 1'b1;
              end
            end
          end
          HOLDOFF: begin
            if (cnt == CNT_ONE) state <= IDLE;
            else                cnt   <= cnt - 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Output buffer handshake: an event transfers on any posedge where event_valid && event_ready;
  // event_amp/event_ts are stable while event_valid && !event_ready. A capture may refill the
  // buffer in the same edge it is popped; a capture into a full, unpopped buffer is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      event_valid <= 1'b0;
      event_amp   <= '0;
      event_ts    <= '0;
      drop_cnt    <= '0;
    end else if (capture) begin
      if (!event_valid || event_ready) begin
        event_valid <= 1'b1;
        event_amp   <= peak_sample;
        event_ts    <= ts_latch;
      end else if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end else if (event_valid && event_ready) begin
      event_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_v1_peak_ctrl.sv
// Randomized bench for v1_peak_ctrl against a time-window reference model; small stat/timestamp
// widths so saturation and timestamp wrap are reached.
module tb_v1_peak_ctrl;
  localparam int DW  = 16;
  localparam int TSW = 10;
  localparam int CW  = 8;
  localparam int SW  = 4;
  localparam int SAT = (1 << SW) - 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          enable = 1'b0;
  logic [DW-1:0] filter_data = '0;
  logic [DW-1:0] threshold = '0;
  logic [CW-1:0] peak_delay = '0;
  logic [CW-1:0] holdoff = '0;
  logic          event_ready = 1'b0;
  logic          event_valid;
  logic [DW-1:0] event_amp;
  logic [TSW-1:0] event_ts;
  logic          busy;
  logic [SW-1:0] drop_cnt;
  logic [SW-1:0] reject_cnt;
  logic [1:0]    state_dbg;

  v1_peak_ctrl #(.DW(DW), .TS_WIDTH(TSW), .CNT_WIDTH(CW), .STAT_WIDTH(SW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .filter_data(filter_data), .threshold(threshold),
    .peak_delay(peak_delay), .holdoff(holdoff), .event_valid(event_valid), .event_ready(event_ready),
    .event_amp(event_amp), .event_ts(event_ts), .busy(busy), .drop_cnt(drop_cnt),
    .reject_cnt(reject_cnt), .state_dbg(state_dbg)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // reference model: activity described as time windows measured in cycle numbers
  longint cyc = 0;
  longint free_at = 0;
  longint arm_end = 0;
  bit armed = 0;
  int run_max = 0;
  logic [TSW-1:0] m_ts = '0;
  logic [TSW-1:0] arm_ts = '0;
  bit m_above_d = 0;
  bit m_valid = 0;
  logic [DW-1:0] m_amp = '0;
  logic [TSW-1:0] m_evts = '0;
  int m_drop = 0;
  int m_reject = 0;
  logic [TSW+DW-1:0] exp_q[$];

  task automatic model_reset();
    free_at = cyc; armed = 0; m_ts = '0; m_above_d = 0; m_valid = 0;
    m_amp = '0; m_evts = '0; m_drop = 0; m_reject = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input int fd, input int thr, input int pd, input int ho,
                            input bit en, input bit rdy);
    bit above;
    bit cap;
    int dly;
    int hh;
    int cap_amp;
    above = fd > thr;
    dly = (pd == 0) ? 1 : pd;
    hh = (ho == 0) ? 1 : ho;
    cap = 0;
    cap_amp = fd;
    if (!en) begin
      armed = 0;
      if (free_at > cyc + 1) free_at = cyc + 1;
    end else if (armed) begin
      if (!above) begin
        armed = 0;
        if (m_reject < SAT) m_reject++;
        free_at = cyc + 1;
      end else begin
        if (fd > run_max) run_max = fd;
        if (cyc == arm_end) begin
          cap = 1;
          armed = 0;
          free_at = cyc + 1 + hh;
        end
      end
    end else if (cyc >= free_at && above && !m_above_d) begin
      armed = 1;
      arm_end = cyc + dly;
      arm_ts = m_ts;
      run_max = -(1 << (DW - 1));
    end
`ifdef V1_PEAK_MAX_EN
    cap_amp = run_max;
`endif
    if (cap) begin
      if (!m_valid || rdy) begin
        m_valid = 1;
        m_amp = DW'(cap_amp);
        m_evts = arm_ts;
        exp_q.push_back({arm_ts, DW'(cap_amp)});
      end else if (m_drop < SAT) begin
        m_drop++;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    m_ts = m_ts + 1'b1;
    m_above_d = above;
    cyc++;
  endtask

  // driver: check state left by the previous edge, drive one cycle, advance the model
  task automatic run_cycle(input int fd, input int thr, input int pd, input int ho,
                           input bit en, input bit rdy);
    logic [TSW+DW-1:0] got;
    @(negedge clk);
    check_eq("valid", event_valid, m_valid);
    check_eq("busy", busy, armed || (cyc < free_at));
    check_eq("drop_cnt", drop_cnt, m_drop);
    check_eq("reject_cnt", reject_cnt, m_reject);
    if (m_valid) begin
      check_eq("event_amp", event_amp, m_amp);
      check_eq("event_ts", event_ts, m_evts);
    end
    filter_data = DW'(fd);
    threshold = DW'(thr);
    peak_delay = CW'(pd);
    holdoff = CW'(ho);
    enable = en;
    event_ready = rdy;
    if (event_valid && rdy) begin
      check_eq("pop_avail", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        got = exp_q.pop_front();
        check_eq("pop_event", {event_ts, event_amp}, got);
      end
    end
    model_step(fd, thr, pd, ho, en, rdy);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, event_valid, 0);
    check_eq({tag, "_amp"}, event_amp, 0);
    check_eq({tag, "_ts"}, event_ts, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_drop"}, drop_cnt, 0);
    check_eq({tag, "_reject"}, reject_cnt, 0);
  endtask

  int thr_r = 100;
  int pd_r = 4;
  int ho_r = 2;

  task automatic random_phase(input int n);
    int seg_len;
    int level;
    int fd;
    bit seg_above;
    bit seg_jitter;
    bit rdy_mode;
    bit rdy;
    seg_len = 0; level = 0; seg_above = 0; seg_jitter = 0; rdy_mode = 1;
    for (int i = 0; i < n; i++) begin
      if (seg_len == 0) begin
        seg_len = $urandom_range(1, 12);
        seg_above = $urandom_range(0, 1) == 1;
        seg_jitter = $urandom_range(0, 2) == 0;
        level = thr_r + int'($urandom_range(1, 600));
        if ($urandom_range(0, 15) == 0) pd_r = $urandom_range(0, 7);
        if ($urandom_range(0, 15) == 0) ho_r = $urandom_range(0, 5);
        if ($urandom_range(0, 31) == 0) thr_r = int'($urandom_range(0, 400)) - 200;
        if ($urandom_range(0, 7) == 0) rdy_mode = ~rdy_mode;
      end
      if (seg_above) fd = seg_jitter ? thr_r + int'($urandom_range(1, 600)) : level;
      else           fd = thr_r - int'($urandom_range(0, 400));
      rdy = rdy_mode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      run_cycle(fd, thr_r, pd_r, ho_r, $urandom_range(0, 99) != 0, rdy);
      seg_len--;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b1;
    model_reset();

    // step to 500, delay 4, always ready
    for (int i = 0; i < 5; i++)  run_cycle(0, 100, 4, 2, 1, 1);
    for (int i = 0; i < 20; i++) run_cycle(500, 100, 4, 2, 1, 1);
    for (int i = 0; i < 5; i++)  run_cycle(0, 100, 4, 2, 1, 1);
    // short pulse rejected
    for (int i = 0; i < 3; i++)  run_cycle(500, 100, 6, 2, 1, 1);
    for (int i = 0; i < 10; i++) run_cycle(0, 100, 6, 2, 1, 1);
    // downstream stalled: second event dropped, first held
    for (int i = 0; i < 8; i++)  run_cycle(500, 100, 2, 1, 1, 0);
    for (int i = 0; i < 5; i++)  run_cycle(0, 100, 2, 1, 1, 0);
    for (int i = 0; i < 8; i++)  run_cycle(600, 100, 2, 1, 1, 0);
    for (int i = 0; i < 5; i++)  run_cycle(0, 100, 2, 1, 1, 0);
    for (int i = 0; i < 3; i++)  run_cycle(0, 100, 2, 1, 1, 1);
    // capture coincides with the pop of the previous event
    for (int i = 0; i < 8; i++)  run_cycle(300, 100, 3, 1, 1, 0);
    for (int i = 0; i < 4; i++)  run_cycle(0, 100, 3, 1, 1, 0);
    for (int i = 0; i < 8; i++)  run_cycle(700, 100, 3, 1, 1, i == 3);
    for (int i = 0; i < 4; i++)  run_cycle(0, 100, 3, 1, 1, 1);
    // ramp inside the flat-top window
    run_cycle(0, 100, 4, 1, 1, 1);
    run_cycle(150, 100, 4, 1, 1, 1);
    run_cycle(200, 100, 4, 1, 1, 1);
    run_cycle(300, 100, 4, 1, 1, 1);
    run_cycle(400, 100, 4, 1, 1, 1);
    run_cycle(350, 100, 4, 1, 1, 1);
    for (int i = 0; i < 5; i++)  run_cycle(0, 100, 4, 1, 1, 1);

    random_phase(4000);

    // asynchronous reset while a pulse is in its flat-top window
    run_cycle(0, 100, 8, 2, 1, 1);
    for (int i = 0; i < 3; i++) run_cycle(500, 100, 8, 2, 1, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    filter_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) run_cycle(0, 100, 8, 2, 1, 1);

    random_phase(1500);
    for (int i = 0; i < 20; i++) run_cycle(0, 100, 2, 1, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
